lcd_spi_sink: RTL and testbench

- Receive-side model of the 4-wire LCD SPI link: sclk, mosi, cs, dc.
- Oversamples the link in the 25 MHz system domain and deserializes mode-0 bytes, MSB first.
- Decodes the CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) commands, then reassembles RGB565 pixels with x/y coordinates.
- Used as a synthesizable loopback checker for the 240x160 panel driver, and as the bench-side panel model.

---
 rtl/lcd_spi_sink.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lcd_spi_sink.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lcd_spi_sink: oversampling 4-wire LCD SPI receiver with CASET/RASET/RAMWR    |
// | decoding and RGB565 pixel reassembly with window coordinates.                |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module lcd_spi_sink #(
   parameter int H_RES = 240,
   parameter int V_RES = 160
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   input  logic        spi_cs,
   input  logic        spi_dc,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_data,
   output logic        cmd_valid,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        frame_done,
   output logic        win_err
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CASET_P = 2'd1;
   localparam logic [1:0] ST_RASET_P = 2'd2;
   localparam logic [1:0] ST_RAMWR   = 2'd3;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int         XE_I   = H_RES - 1;
   localparam int         YE_I   = V_RES - 1;
   localparam logic [8:0] XE_RST = XE_I[8:0];
   localparam logic [8:0] YE_RST = YE_I[8:0];
   localparam logic [15:0] H_LIM = H_RES[15:0];
   localparam logic [15:0] V_LIM = V_RES[15:0];

   // ---------------------------------------------------------------- sync
   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic mosi_s1_q, mosi_s2_q;
   logic cs_s1_q, cs_s2_q;
   logic dc_s1_q, dc_s2_q;
   logic rise_w;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         dc_s1_q   <= 1'b0;
         dc_s2_q   <= 1'b0;
      end else begin
         sclk_s1_q <= spi_sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         mosi_s1_q <= spi_mosi;
         mosi_s2_q <= mosi_s1_q;
         cs_s1_q   <= spi_cs;
         cs_s2_q   <= cs_s1_q;
         dc_s1_q   <= spi_dc;
         dc_s2_q   <= dc_s1_q;
      end
   end

   assign rise_w = sclk_s2_q & ~sclk_s3_q & ~cs_s2_q;

   // -------------------------------------------------------- deserializer
   logic       rise_q, bit_q, bdc_q;
   logic [2:0] cnt_q;
   logic [6:0] shift_q;
   logic       full_q, asm_dc_q;
   logic [7:0] asm_q;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         rise_q   <= 1'b0;
         bit_q    <= 1'b0;
         bdc_q    <= 1'b0;
         cnt_q    <= 3'd0;
         shift_q  <= 7'd0;
         full_q   <= 1'b0;
         asm_q    <= 8'd0;
         asm_dc_q <= 1'b0;
      end else begin
         rise_q <= rise_w;
         if (rise_w) begin
            bit_q <= mosi_s2_q;
            bdc_q <= dc_s2_q;
         end
         full_q <= 1'b0;
         if (cs_s2_q) begin
            cnt_q <= 3'd0;
         end else if (rise_q) begin
            shift_q <= {shift_q[5:0], bit_q};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               full_q   <= 1'b1;
               asm_q    <= {shift_q, bit_q};
               asm_dc_q <= bdc_q;
            end
         end
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         byte_valid   <= 1'b0;
         byte_data    <= 8'd0;
         byte_is_data <= 1'b0;
         cmd_valid    <= 1'b0;
      end else begin
         byte_valid <= full_q;
         cmd_valid  <= full_q & ~asm_dc_q;
         if (full_q) begin
            byte_data    <= asm_q;
            byte_is_data <= asm_dc_q;
         end
      end
   end

   // ------------------------------------------------------------- decoder
   logic [1:0]  state_q, state_d;
   logic [1:0]  pidx_q, pidx_d;
   logic [23:0] sh_q, sh_d;
   logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [8:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic        half_q, half_d;
   logic [7:0]  hi_q, hi_d;
   logic        pix_valid_d, frame_done_d, win_err_d;
   logic [15:0] pix_data_d;
   logic [8:0]  pix_x_d, pix_y_d;
   logic [15:0] start_w, end_w;
   logic        is_cmd_w, is_dat_w;

   assign is_cmd_w = byte_valid & ~byte_is_data;
   assign is_dat_w = byte_valid &  byte_is_data;
   assign start_w  = sh_q[23:8];
   assign end_w    = {sh_q[7:0], byte_data};

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (is_cmd_w) begin
         case (byte_data)
            CMD_CASET: state_d = ST_CASET_P;
            CMD_RASET: state_d = ST_RASET_P;
            CMD_RAMWR: state_d = ST_RAMWR;
            default:   state_d = ST_IDLE;
         endcase
      end else if (is_dat_w && pidx_q == 2'd3 &&
                   (state_q == ST_CASET_P || state_q == ST_RASET_P)) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      pidx_d       = pidx_q;
      sh_d         = sh_q;
      xs_d         = xs_q;
      xe_d         = xe_q;
      ys_d         = ys_q;
      ye_d         = ye_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      half_d       = half_q;
      hi_d         = hi_q;
      win_err_d    = win_err;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      pix_data_d   = pix_data;
      pix_x_d      = pix_x;
      pix_y_d      = pix_y;
      if (is_cmd_w) begin
         pidx_d = 2'd0;
         half_d = 1'b0;
         if (byte_data == CMD_RAMWR) begin
            cur_x_d = xs_q;
            cur_y_d = ys_q;
         end
      end else if (is_dat_w) begin
         case (state_q)
            ST_CASET_P, ST_RASET_P: begin
               pidx_d = pidx_q + 2'd1;
               case (pidx_q)
                  2'd0:    sh_d[23:16] = byte_data;
                  2'd1:    sh_d[15:8]  = byte_data;
                  2'd2:    sh_d[7:0]   = byte_data;
                  default: begin
                     // Window committed only if the full 16-bit bounds are legal
                     if (state_q == ST_CASET_P) begin
                        if (start_w <= end_w && end_w < H_LIM) begin
                           xs_d = start_w[8:0];
                           xe_d = end_w[8:0];
                        end else begin
                           win_err_d = 1'b1;
                        end
                     end else begin
                        if (start_w <= end_w && end_w < V_LIM) begin
                           ys_d = start_w[8:0];
                           ye_d = end_w[8:0];
                        end else begin
                           win_err_d = 1'b1;
                        end
                     end
                  end
               endcase
            end
            ST_RAMWR: begin
               if (!half_q) begin
                  hi_d   = byte_data;
                  half_d = 1'b1;
               end else begin
                  half_d      = 1'b0;
                  pix_valid_d = 1'b1;
                  pix_data_d  = {hi_q, byte_data};
                  pix_x_d     = cur_x_q;
                  pix_y_d     = cur_y_q;
                  if (cur_x_q != xe_q) begin
                     cur_x_d = cur_x_q + 9'd1;
                  end else begin
                     cur_x_d = xs_q;
                     if (cur_y_q == ye_q) begin
                        cur_y_d      = ys_q;
                        frame_done_d = 1'b1;
                     end else begin
                        cur_y_d = cur_y_q + 9'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         pidx_q     <= 2'd0;
         sh_q       <= 24'd0;
         xs_q       <= 9'd0;
         xe_q       <= XE_RST;
         ys_q       <= 9'd0;
         ye_q       <= YE_RST;
         cur_x_q    <= 9'd0;
         cur_y_q    <= 9'd0;
         half_q     <= 1'b0;
         hi_q       <= 8'd0;
         win_err    <= 1'b0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         pix_data   <= 16'd0;
         pix_x      <= 9'd0;
         pix_y      <= 9'd0;
      end else begin
         pidx_q     <= pidx_d;
         sh_q       <= sh_d;
         xs_q       <= xs_d;
         xe_q       <= xe_d;
         ys_q       <= ys_d;
         ye_q       <= ye_d;
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
         half_q     <= half_d;
         hi_q       <= hi_d;
         win_err    <= win_err_d;
         pix_valid  <= pix_valid_d;
         frame_done <= frame_done_d;
         pix_data   <= pix_data_d;
         pix_x      <= pix_x_d;
         pix_y      <= pix_y_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_lcd_spi_sink: directed bench for lcd_spi_sink, reduced 24x16 panel so a   |
// | full frame fits in a short run. Rev 1.0                                      |
// +-----------------------------------------------------------------------------+
module tb_lcd_spi_sink;

   localparam int HR = 24;
   localparam int VR = 16;

   logic        clk_25MHz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        spi_sclk  = 1'b0;
   logic        spi_mosi  = 1'b0;
   logic        spi_cs    = 1'b1;
   logic        spi_dc    = 1'b0;
   logic        byte_valid, byte_is_data, cmd_valid, pix_valid, frame_done, win_err;
   logic [7:0]  byte_data;
   logic [15:0] pix_data;
   logic [8:0]  pix_x, pix_y;

   lcd_spi_sink #(.H_RES(HR), .V_RES(VR)) dut (
      .clk_25MHz   (clk_25MHz),
      .rst_n       (rst_n),
      .spi_sclk    (spi_sclk),
      .spi_mosi    (spi_mosi),
      .spi_cs      (spi_cs),
      .spi_dc      (spi_dc),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_is_data(byte_is_data),
      .cmd_valid   (cmd_valid),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_done  (frame_done),
      .win_err     (win_err)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   int n_checks = 0;
   int n_errors = 0;
   int n_bytes  = 0;
   logic [7:0]  last_byte = 8'd0;
   logic        last_cmd  = 1'b0;
   logic        last_isd  = 1'b0;
   // {frame_done, y, x, data}
   logic [34:0] pix_q[$];

   always @(negedge clk_25MHz) begin
      if (byte_valid) begin
         n_bytes++;
         last_byte = byte_data;
         last_cmd  = cmd_valid;
         last_isd  = byte_is_data;
      end
      if (pix_valid) pix_q.push_back({frame_done, pix_y, pix_x, pix_data});
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_25MHz);
      #1;
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      repeat (2) @(posedge clk_25MHz);
      #13 spi_sclk = 1'b1;
      repeat (2) @(posedge clk_25MHz);
      #13 spi_sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, input logic dc);
      spi_dc = dc;
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic cmd(input logic [7:0] b);
      spi_byte(b, 1'b0);
   endtask

   task automatic dat(input logic [7:0] b);
      spi_byte(b, 1'b1);
   endtask

   task automatic do_reset();
      spi_sclk = 1'b0;
      rst_n    = 1'b0;
      wait_clk(3);
      #12 rst_n = 1'b1;
      spi_cs   = 1'b0;
      wait_clk(4);
   endtask

   int bad, fdn, nb0, nq0;
   logic [34:0] e;
   logic [8:0]  exp_x [5];
   logic [8:0]  exp_y [5];
   logic        exp_f [5];

   initial begin
      exp_x = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
      exp_y = '{9'd5,  9'd5,  9'd6,  9'd6,  9'd5};
      exp_f = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

      do_reset();
      check_val("rst_outputs", {byte_valid, byte_data, byte_is_data, cmd_valid, pix_valid}, 32'd0);
      check_val("rst_pix", {pix_data, pix_x, pix_y, frame_done, win_err}, 32'd0);

      // Full frame over the whole panel
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h17);
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h0F);
      cmd(8'h2C);
      for (int p = 0; p < HR * VR; p++) begin
         dat(8'hF8); dat(8'h00);
      end
      wait_clk(10);
      bad = 0; fdn = 0;
      foreach (pix_q[i]) begin
         if (pix_q[i][15:0] !== 16'hF800) bad++;
         if (pix_q[i][34]) fdn++;
      end
      check_val("frame_count", pix_q.size(), HR * VR);
      check_val("frame_data_bad", bad, 0);
      check_val("frame_done_count", fdn, 1);
      check_val("frame_first_xy", {pix_q[0][33:25], pix_q[0][24:16]}, {9'd0, 9'd0});
      e = pix_q[pix_q.size() - 1];
      check_val("frame_last_xy", {e[33:25], e[24:16]}, {9'd15, 9'd23});
      check_val("frame_last_done", e[34], 1);
      check_val("frame_win_err", win_err, 0);

      // Small 2x2 window with wrap
      pix_q.delete();
      cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
      cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
      cmd(8'h2C);
      for (int p = 0; p < 5; p++) begin
         dat(8'h10); dat(8'(p));
      end
      wait_clk(10);
      check_val("win_count", pix_q.size(), 5);
      for (int p = 0; p < 5; p++) begin
         e = pix_q[p];
         check_val($sformatf("win_px%0d_xy", p), {e[33:25], e[24:16]}, {exp_y[p], exp_x[p]});
         check_val($sformatf("win_px%0d_done", p), e[34], exp_f[p]);
         check_val($sformatf("win_px%0d_data", p), e[15:0], 32'h1000 + p);
      end

      // Partial byte discarded by cs deassertion
      nb0 = n_bytes;
      spi_dc = 1'b1;
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      wait_clk(2);
      spi_cs = 1'b1;
      wait_clk(5);
      spi_cs = 1'b0;
      wait_clk(4);
      cmd(8'h2C);
      wait_clk(8);
      check_val("partial_bytes", n_bytes - nb0, 1);
      check_val("partial_data", last_byte, 8'h2C);
      check_val("partial_cmd", {last_cmd, last_isd}, 2'b10);

      // Orphan high byte dropped by intervening command; idle data ignored
      pix_q.delete();
      dat(8'h12);
      cmd(8'h00);
      dat(8'h99);
      wait_clk(8);
      check_val("idle_data_byte", {last_byte, last_isd}, {8'h99, 1'b1});
      cmd(8'h2C);
      dat(8'h34); dat(8'h56);
      wait_clk(10);
      check_val("orphan_count", pix_q.size(), 1);
      e = pix_q[0];
      check_val("orphan_data", e[15:0], 16'h3456);
      check_val("orphan_xy", {e[33:25], e[24:16]}, {9'd5, 9'd10});

      // Illegal windows
      do_reset();
      cmd(8'h2A); dat(8'h00); dat(8'h03); dat(8'h00); dat(8'h02);
      wait_clk(8);
      check_val("err_xs_gt_xe", win_err, 1);
      do_reset();
      check_val("err_cleared_by_rst", win_err, 0);
      pix_q.delete();
      cmd(8'h2A); dat(8'h00); dat(8'hF0); dat(8'h00); dat(8'hF5);
      wait_clk(8);
      check_val("err_xs_range", win_err, 1);
      cmd(8'h2C); dat(8'hAB); dat(8'hCD);
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h17);
      wait_clk(8);
      check_val("err_pix_count", pix_q.size(), 1);
      e = pix_q[0];
      check_val("err_pix_xy", {e[33:25], e[24:16], e[15:0]}, {9'd0, 9'd0, 16'hABCD});
      check_val("err_sticky", win_err, 1);

      // Latency of a byte, then async reset mid-pixel
      do_reset();
      cmd(8'h2A); dat(8'h00); dat(8'h03); dat(8'h00); dat(8'h05);
      cmd(8'h2C);
      dat(8'hAA);
      wait_clk(6);
      pix_q.delete();
      spi_dc = 1'b1;
      for (int i = 7; i >= 1; i--) spi_bit(1'(8'h77 >> i));
      spi_mosi = 1'b1;
      repeat (2) @(posedge clk_25MHz);
      #13 spi_sclk = 1'b1;
      @(posedge clk_25MHz);
      repeat (3) @(posedge clk_25MHz);
      #1 check_val("lat_not_early", byte_valid, 0);
      @(posedge clk_25MHz);
      #1 check_val("lat_4clk", {byte_valid, byte_data, byte_is_data}, {1'b1, 8'h77, 1'b1});
      #4 rst_n = 1'b0;
      #1 check_val("async_rst_outputs", {byte_valid, byte_data, byte_is_data, cmd_valid, pix_valid, frame_done, win_err}, 32'd0);
      check_val("async_rst_pix", {pix_data, pix_x, pix_y}, 32'd0);
      spi_sclk = 1'b0;
      wait_clk(6);
      check_val("rst_no_pixel", pix_q.size(), 0);
      #12 rst_n = 1'b1;
      wait_clk(4);
      cmd(8'h2C); dat(8'h11); dat(8'h22);
      wait_clk(10);
      check_val("post_rst_count", pix_q.size(), 1);
      e = pix_q[0];
      check_val("post_rst_pix", {e[33:25], e[24:16], e[15:0]}, {9'd0, 9'd0, 16'h1122});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
